// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA timing source for the renderer pixel interface.
// Issues pixel coordinates one clock ahead of display. Registers sync, de and rgb
// so the renderer's single pipeline stage lines up with the DAC outputs.
// Optional build macro VGA_TIMING_CTRL_TEST_PATTERN_EN adds a test_mode_i input
// that replaces renderer data with 8 vertical colour bars.
module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        vga_clk_i,
  input  logic        rst_i,
`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
  input  logic        test_mode_i,
`endif
  input  logic [23:0] pos_data_i,
  output logic [9:0]  pos_x_o,
  output logic [9:0]  pos_y_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        frame_start_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0     = H_SYNC + H_BACK;
  localparam int VA0     = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA0_C    = 10'(HA0);
  localparam logic [9:0] HA_END_C = 10'(HA0 + H_ACTIVE);
  localparam logic [9:0] VA0_C    = 10'(VA0);
  localparam logic [9:0] VA_END_C = 10'(VA0 + V_ACTIVE);
  // Request window leads the display window by one clock (renderer stage).
  localparam logic [9:0] REQ_LO   = 10'(HA0 - 1);
  localparam logic [9:0] REQ_HI   = 10'(HA0 + H_ACTIVE - 2);
  localparam logic [9:0] HS_C     = 10'(H_SYNC);
  localparam logic [9:0] VS_C     = 10'(V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_disp, v_disp, req;
  logic        frame_top;
  logic [23:0] pix_d;
  logic [23:0] rgb_d;

  // Next-state for the line and frame counters; v advances only on h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Display windows and the combinational coordinate request.
  always_comb begin
    h_disp    = (h_cnt_q >= HA0_C) && (h_cnt_q < HA_END_C);
    v_disp    = (v_cnt_q >= VA0_C) && (v_cnt_q < VA_END_C);
    req       = v_disp && (h_cnt_q >= REQ_LO) && (h_cnt_q <= REQ_HI);
    pos_x_o   = req ? (h_cnt_q - REQ_LO) : '0;
    pos_y_o   = v_disp ? (v_cnt_q - VA0_C) : '0;
    frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
  logic [9:0]  col_w;
  logic [2:0]  bar_w;
  logic [23:0] bar_rgb;

  // Colour bar lookup, 80-pixel bars across the displayed column.
  always_comb begin
    col_w = h_cnt_q - HA0_C;
    bar_w = 3'(col_w / 10'd80);
    case (bar_w)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    pix_d = test_mode_i ? bar_rgb : pos_data_i;
  end
`else
  // Pixel source is always the renderer.
  always_comb pix_d = pos_data_i;
`endif

  // Blank rgb outside the visible area regardless of renderer data.
  always_comb rgb_d = (h_disp && v_disp) ? pix_d : '0;

  // Registered DAC outputs and frame markers, all one stage behind the counters.
  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      de_o          <= 1'b0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      hsync_o       <= (h_cnt_q >= HS_C);
      vsync_o       <= (v_cnt_q >= VS_C);
      de_o          <= h_disp && v_disp;
      rgb_o         <= rgb_d;
      frame_start_o <= frame_top;
      if (frame_top) frame_cnt_o <= frame_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with shrunken timing so hundreds of frames fit in a short run.
// A posedge process models the counters and queues expected rgb per visible pixel;
// a negedge monitor compares all outputs and pops the queue whenever de is high.
module tb_vga_timing_ctrl;
  localparam int HS = 3, HB = 2, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 6, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 15
  localparam int VT = VS + VB + VA + VF;   // 11
  localparam int HA0 = HS + HB;            // 5
  localparam int VA0 = VS + VB;            // 4
  localparam int FT = HT * VT;             // 165

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pos_data = '0;
  logic [9:0]  pos_x, pos_y;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .vga_clk_i    (clk),
    .rst_i        (rst),
`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
    .test_mode_i  (1'b0),
`endif
    .pos_data_i   (pos_data),
    .pos_x_o      (pos_x),
    .pos_y_o      (pos_y),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .de_o         (de),
    .rgb_o        (rgb),
    .frame_start_o(frame_start),
    .frame_cnt_o  (frame_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // One-stage renderer: returns {y, x, A5}, or constant white in blanking-test mode.
  logic rend_const = 1'b0;
  logic rend_const_q = 1'b0;
  always @(posedge clk) begin
    rend_const_q <= rend_const;
    pos_data     <= rend_const ? 24'hFFFFFF : {pos_y[7:0], pos_x[7:0], 8'hA5};
  end

  // Counter model and expected-response generator.
  logic [23:0] exp_q[$];
  int   mh = 0, mv = 0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0;
  logic [7:0] e_fc = '0;
  always @(posedge clk) begin
    if (rst) begin
      mh = 0; mv = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_fc = '0;
      exp_q.delete();
    end else begin
      e_hs = (mh >= HS);
      e_vs = (mv >= VS);
      e_de = (mh >= HA0) && (mh < HA0 + HA) && (mv >= VA0) && (mv < VA0 + VA);
      e_fs = (mh == 0) && (mv == 0);
      if (e_fs) e_fc = e_fc + 8'd1;
      if (e_de)
        exp_q.push_back(rend_const_q ? 24'hFFFFFF : {8'(mv - VA0), 8'(mh - HA0), 8'hA5});
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  // Monitor: output compare, scoreboard pop, period measurements.
  int   cyc = 0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_de = 1'b0;
  logic have_hf = 1'b0, have_fs = 1'b0;
  int   last_hf = 0, last_fs = 0, hlow = 0, vlow = 0, drun = 0, dlines = 0;
  logic [7:0] p_fc = '0;
  logic wrap_seen = 1'b0;
  always @(negedge clk) begin
    logic [23:0] ex;
    logic        vd, rq;
    cyc++;
    if (rst) begin
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_de", de, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_pos_x", pos_x, 0);
      chk("rst_pos_y", pos_y, 0);
      p_hs = 1'b1; p_vs = 1'b1; p_de = 1'b0; have_hf = 1'b0; have_fs = 1'b0;
      hlow = 0; vlow = 0; drun = 0; dlines = 0; p_fc = '0;
    end else begin
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("de", de, e_de);
      chk("frame_start", frame_start, e_fs);
      chk("frame_cnt", frame_cnt, e_fc);
      vd = (mv >= VA0) && (mv < VA0 + VA);
      rq = vd && (mh >= HA0 - 1) && (mh <= HA0 + HA - 2);
      chk("pos_x", pos_x, rq ? 32'(mh - (HA0 - 1)) : 0);
      chk("pos_y", pos_y, vd ? 32'(mv - VA0) : 0);
      if (de) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
        else begin
          ex = exp_q.pop_front();
          chk("rgb_pixel", rgb, ex);
        end
      end else begin
        chk("rgb_blank", rgb, 0);
      end
      // hsync period and pulse width
      if (!hsync) begin
        if (p_hs) begin
          if (have_hf) chk("hsync_period", cyc - last_hf, HT);
          have_hf = 1'b1; last_hf = cyc; hlow = 0;
        end
        hlow++;
      end else if (!p_hs) chk("hsync_low_len", hlow, HS);
      // vsync pulse width
      if (!vsync) begin
        if (p_vs) vlow = 0;
        vlow++;
      end else if (!p_vs) chk("vsync_low_len", vlow, VS * HT);
      // de run length and visible line count
      if (de) begin
        if (!p_de) dlines++;
        drun++;
      end else if (p_de) begin
        chk("de_run_len", drun, HA);
        drun = 0;
      end
      // frame period, line count per frame, counter wrap
      if (frame_start) begin
        if (have_fs) begin
          chk("frame_period", cyc - last_fs, FT);
          chk("de_lines", dlines, VA);
        end
        if (p_fc == 8'hFF) begin
          chk("frame_cnt_wrap", frame_cnt, 0);
          wrap_seen = 1'b1;
        end
        have_fs = 1'b1; last_fs = cyc; dlines = 0;
      end
      p_hs = hsync; p_vs = vsync; p_de = de; p_fc = frame_cnt;
    end
  end

  initial begin
    rst = 1'b1;
    rend_const = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2 * FT + 20) @(negedge clk);
    #1 rend_const = 1'b1;
    repeat (FT) @(negedge clk);
    #1 rend_const = 1'b0;
    repeat (FT + 70) @(negedge clk);
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    repeat (258 * FT + 10) @(negedge clk);
    chk("scoreboard_drain", (exp_q.size() <= 1) ? 1 : 0, 1);
    chk("wrap_seen", wrap_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
